// File: rtl/wb_decoder.sv
// Wishbone address decoder and response mux. Upper address bits pick one peripheral, and the request is registered into BUSY.
// Latency: the ack comes 2+ cycles after the stb edge (1 cycle if unmapped). Unmapped or stalled accesses end with an error ack.
module wb_decoder #(
  parameter int              AddrW         = 4,
  parameter int              DataW         = 8,
  parameter int              PeriAddrW     = 2,
  parameter int              PeriN         = 4,
  parameter int              TimeoutCycles = 15,
  parameter logic [DataW-1:0] ErrData      = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ctrl_wb_we_i,
  input  logic [AddrW-1:0]       ctrl_wb_adr_i,
  input  logic [DataW-1:0]       ctrl_wb_dat_i,
  input  logic                   ctrl_wb_stb_i,
  output logic [DataW-1:0]       ctrl_wb_dat_o,
  output logic                   ctrl_wb_ack_o,
  output logic                   peri_wb_we_o,
  output logic [PeriAddrW-1:0]   peri_wb_adr_o,
  output logic [DataW-1:0]       peri_wb_dat_o,
  output logic [PeriN-1:0]       peri_wb_stb_o,
  input  logic [PeriN*DataW-1:0] peri_wb_dat_i,
  input  logic [PeriN-1:0]       peri_wb_ack_i,
  output logic                   err_o,
  output logic [7:0]             err_cnt_o
);

  localparam int SelW   = AddrW - PeriAddrW;
  localparam int TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [SelW:0]     PeriNLim  = (SelW+1)'(PeriN);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q, state_d;
  logic               we_q;
  logic [AddrW-1:0]   adr_q;
  logic [DataW-1:0]   wdat_q;
  logic [DataW-1:0]   rdat_q;
  logic [TimerW-1:0]  timer_q;
  logic               err_q;
  logic [7:0]         err_cnt_q;

  logic [SelW-1:0]    sel_in;
  logic [SelW-1:0]    sel_q;
  logic               in_mapped;
  logic [PeriN-1:0]   sel_oh;
  logic [DataW-1:0]   sel_rdat;
  logic               sel_ack;
  logic               timeout;

  assign sel_in    = ctrl_wb_adr_i[AddrW-1:PeriAddrW];
  assign sel_q     = adr_q[AddrW-1:PeriAddrW];
  assign in_mapped = ({1'b0, sel_in} < PeriNLim);
  assign timeout   = (timer_q == TimerLast);

  // The one-hot select doubles as the strobe vector and the ack/data mask.
  always_comb begin
    sel_oh   = '0;
    sel_rdat = '0;
    for (int k = 0; k < PeriN; k++) begin
      sel_oh[k] = (sel_q == SelW'(k));
      if (sel_oh[k]) sel_rdat = peri_wb_dat_i[k*DataW +: DataW];
    end
  end

  assign sel_ack = |(sel_oh & peri_wb_ack_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl_wb_stb_i) state_d = in_mapped ? BUSY : RESP;
      BUSY:    if (sel_ack || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (ctrl_wb_stb_i) begin
          we_q    <= ctrl_wb_we_i;
          adr_q   <= ctrl_wb_adr_i;
          wdat_q  <= ctrl_wb_dat_i;
          timer_q <= '0;
          err_q   <= !in_mapped;
          if (!in_mapped) rdat_q <= ErrData;
        end
        // The ack is checked before the timeout, so an ack on the last timer cycle still completes normally.
        BUSY: begin
          if (sel_ack) begin
            rdat_q <= sel_rdat;
          end else if (timeout) begin
            err_q  <= 1'b1;
            rdat_q <= ErrData;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        default: ;
      endcase
    end
  end

  assign ctrl_wb_ack_o = (state_q == RESP);
  assign err_o         = (state_q == RESP) && err_q;
  assign ctrl_wb_dat_o = rdat_q;
  assign peri_wb_stb_o = (state_q == BUSY) ? sel_oh : '0;
  assign peri_wb_we_o  = we_q;
  assign peri_wb_adr_o = adr_q[PeriAddrW-1:0];
  assign peri_wb_dat_o = wdat_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_wb_decoder.sv
// Randomised bench for wb_decoder with 3 peripherals on a 4-bit address, so sel 3 is unmapped.
// A transaction-level reference model derives the expected ack cycle, data, error flag and error count.
module tb_wb_decoder;
  localparam int AW = 4, DW = 8, PAW = 2, PN = 3, TO = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           we = 1'b0, stb = 1'b0;
  logic [AW-1:0]  adr = '0;
  logic [DW-1:0]  wdat = '0;
  logic [DW-1:0]  rdat;
  logic           ack, err, p_we;
  logic [PAW-1:0] p_adr;
  logic [DW-1:0]  p_dat;
  logic [PN-1:0]  p_stb;
  logic [PN*DW-1:0] p_rdat = '0;
  logic [PN-1:0]  p_ack = '0;
  logic [7:0]     err_cnt;

  int n_vec = 0, n_err = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  wb_decoder #(.AddrW(AW), .DataW(DW), .PeriAddrW(PAW), .PeriN(PN),
               .TimeoutCycles(TO), .ErrData(8'h00)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ctrl_wb_we_i(we), .ctrl_wb_adr_i(adr), .ctrl_wb_dat_i(wdat), .ctrl_wb_stb_i(stb),
    .ctrl_wb_dat_o(rdat), .ctrl_wb_ack_o(ack),
    .peri_wb_we_o(p_we), .peri_wb_adr_o(p_adr), .peri_wb_dat_o(p_dat), .peri_wb_stb_o(p_stb),
    .peri_wb_dat_i(p_rdat), .peri_wb_ack_i(p_ack),
    .err_o(err), .err_cnt_o(err_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // delay = index of the BUSY cycle in which the peripheral acks (>= TO means it never does).
  // Called at a negedge. Reference: unmapped -> error ack 1 cycle after the stb edge;
  // an ack in BUSY cycle d -> ack d+2 cycles later; otherwise an error ack TO+1 cycles later.
  task automatic run_txn(input logic t_we, input logic [AW-1:0] t_adr, input logic [DW-1:0] t_wd,
                         input int delay, input logic [DW-1:0] t_rd, input bit noise, input bit late);
    int sel, lat;
    bit mapped, exp_err;
    logic [DW-1:0] exp_dat;
    logic [PN-1:0] oh;
    sel    = int'(t_adr[AW-1:PAW]);
    mapped = (sel < PN);
    oh     = mapped ? PN'(1 << sel) : '0;
    if (!mapped)         begin lat = 1;         exp_err = 1'b1; exp_dat = 8'h00; end
    else if (delay < TO) begin lat = delay + 2; exp_err = 1'b0; exp_dat = t_rd;  end
    else                 begin lat = TO + 1;    exp_err = 1'b1; exp_dat = 8'h00; end
    chk("err_cnt_idle", 32'(err_cnt), 32'(model_cnt));
    we = t_we; adr = t_adr; wdat = t_wd; stb = 1'b1;
    p_ack = '0;
    for (int cyc = 1; cyc <= lat + 2; cyc++) begin
      @(negedge clk);
      chk("ack", 32'(ack), 32'(cyc == lat));
      chk("err_o", 32'(err), 32'(cyc == lat && exp_err));
      chk("peri_stb", 32'(p_stb), (mapped && cyc < lat) ? 32'(oh) : 32'd0);
      if (mapped && cyc < lat) begin
        chk("peri_adr", 32'(p_adr), 32'(t_adr[PAW-1:0]));
        chk("peri_we",  32'(p_we),  32'(t_we));
        chk("peri_dat", 32'(p_dat), 32'(t_wd));
      end
      if (cyc == lat) begin
        chk("rdat", 32'(rdat), 32'(exp_dat));
        stb = 1'b0;
        if (exp_err && model_cnt < 255) model_cnt++;
      end
      p_rdat = {$urandom, $urandom};
      p_ack  = noise ? (PN'($urandom) & ~oh) : '0;
      if (mapped && cyc < lat && cyc - 1 == delay) begin
        p_ack[sel] = 1'b1;
        p_rdat[sel*DW +: DW] = t_rd;
      end
      if (late && mapped && cyc >= lat) p_ack[sel] = 1'b1;
    end
    p_ack = '0;
  endtask

  initial begin
    #2;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_stb", 32'(p_stb), 32'd0);
    chk("rst_rdat", 32'(rdat), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 4'b1001, 8'h00, 2, 8'hA5, 1'b0, 1'b0);   // read peri 2
    run_txn(1'b1, 4'b0000, 8'h3C, 0, 8'h77, 1'b0, 1'b0);   // write peri 0
    run_txn(1'b0, 4'b1100, 8'h00, 0, 8'h11, 1'b0, 1'b0);   // unmapped
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    run_txn(1'b0, 4'b0110, 8'h00, 99, 8'h22, 1'b0, 1'b1);  // timeout with a late ack
    run_txn(1'b0, 4'b1011, 8'h00, 1, 8'hC3, 1'b1, 1'b0);   // peri 2 with spurious acks
    run_txn(1'b0, 4'b0101, 8'h00, TO-1, 8'h5A, 1'b1, 1'b0); // ack on the last timer cycle

    // Reset mid-BUSY
    we = 1'b1; adr = 4'b0110; wdat = 8'h99; stb = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_stb", 32'(p_stb), 32'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_stb", 32'(p_stb), 32'd0);
    chk("arst_we", 32'(p_we), 32'd0);
    chk("arst_pdat", 32'(p_dat), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    model_cnt = 0;
    stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ack", 32'(ack), 32'd0);
      chk("post_rst_stb", 32'(p_stb), 32'd0);
    end

    for (int i = 0; i < 200; i++)
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, TO + 2),
              DW'($urandom), 1'b1, 1'($urandom));

    // stb held through RESP: an unmapped access then takes exactly 2 cycles.
    adr = 4'b1100; stb = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      chk("hold_ack", 32'(ack), 32'(cyc % 2 == 1));
      if (cyc % 2 == 1 && model_cnt < 255) model_cnt++;
      if (cyc == 10) stb = 1'b0;
    end
    @(negedge clk);
    chk("hold_end_ack", 32'(ack), 32'd0);

    for (int i = 0; i < 300; i++)
      run_txn(1'b0, 4'b1100 | AW'($urandom_range(0, 3)), 8'h00, 0, 8'h00, 1'b0, 1'b0);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_decoder.md
Name: wb_decoder

Overview:
Parametrised Wishbone (classic, single-master) address decoder and response mux between the SPI controller and up to PeriN peripherals. It replaces the hand-written per-peripheral case statement in the top level. It registers each request, steers the strobe to one peripheral selected by the upper address bits, and returns that peripheral's data with a registered ack. Unmapped addresses and stalled peripherals are terminated with a timeout and counted in an error counter.

Parameters:
AddrW, 4, controller address width
DataW, 8, data width
PeriAddrW, 2, low address bits forwarded to peripherals; upper AddrW-PeriAddrW bits select the peripheral
PeriN, 4, number of peripheral ports; must be 1..2**(AddrW-PeriAddrW)
TimeoutCycles, 15, maximum cycles in BUSY waiting for peripheral ack; must be >= 1
ErrData, 0, data returned on an unmapped or timed-out read

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
ctrl_wb_we_i  in  1  controller write enable
ctrl_wb_adr_i  in  AddrW  controller address
ctrl_wb_dat_i  in  DataW  controller write data
ctrl_wb_stb_i  in  1  controller strobe; held until ack
ctrl_wb_dat_o  out  DataW  read data to controller
ctrl_wb_ack_o  out  1  one-cycle ack to controller
peri_wb_we_o  out  1  broadcast write enable
peri_wb_adr_o  out  PeriAddrW  broadcast low address
peri_wb_dat_o  out  DataW  broadcast write data
peri_wb_stb_o  out  PeriN  one-hot per-peripheral strobe
peri_wb_dat_i  in  PeriN*DataW  packed read data; peripheral k at [k*DataW +: DataW]
peri_wb_ack_i  in  PeriN  per-peripheral ack
err_o  out  1  one-cycle pulse coincident with an error-terminated ack
err_cnt_o  out  8  saturating count of error terminations

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset values: state IDLE; all outputs 0, including err_cnt_o and the latched address, we and data.
- Reset is asynchronous. Asserting it mid-transaction aborts immediately: the strobe drops and no ack is issued.
- IDLE:
  - On ctrl_wb_stb_i=1, latch we, adr and dat, and compute sel = adr[AddrW-1:PeriAddrW].
  - If sel < PeriN, go to BUSY and load the timer with 0.
  - If sel >= PeriN, go directly to RESP as an error, with dat_o=ErrData. No peripheral strobe is asserted.
- BUSY:
  - peri_wb_stb_o[sel]=1 and all other strobe bits are 0.
  - peri_wb_we_o, peri_wb_adr_o and peri_wb_dat_o come from the latched values and are stable for the whole BUSY period.
  - If peri_wb_ack_i[sel]=1: capture peri_wb_dat_i slice sel into ctrl_wb_dat_o and go to RESP (normal).
  - Else, if the timer equals TimeoutCycles-1: go to RESP as an error, with dat_o=ErrData.
  - Else: increment the timer.
  - Acks from non-selected peripherals are ignored.
- RESP:
  - ctrl_wb_ack_o=1 for exactly this one cycle. All peri strobes are 0.
  - err_o=1 if the response is an error termination.
  - ctrl_wb_stb_i is ignored in RESP. The next state is always IDLE.
  - A controller holding stb in the IDLE cycle that follows RESP starts a new transaction.
- ctrl_wb_dat_o holds its value outside RESP; only its value during the ack cycle is defined.
- Writes: ctrl_wb_dat_o is still updated from the peripheral slice (or ErrData); the controller ignores it.
- err_cnt_o increments on each error RESP and saturates at 255. It is not cleared except by reset.
- A late peripheral ack after a timeout arrives in RESP or IDLE and is ignored. The peripheral's strobe is already low.
- Latency:
  - Mapped access with a peripheral that acks in its first BUSY cycle: stb seen at edge N, peri stb during cycle N+1, ctrl ack during cycle N+2.
  - Unmapped access: ack during cycle N+1.
  - Timeout: ack TimeoutCycles+1 cycles after the stb edge.
- A peripheral ack at the same edge that the timer reaches TimeoutCycles-1 counts as a normal completion; ack has priority.
- Back-to-back transactions: at most one transaction every 3 cycles for mapped addresses.

Test Plan:
- Reset mid-BUSY: assert rst_ni=0 while peri_wb_stb_o[1]=1 -> all outputs 0 immediately; state IDLE after release; no ack.
- Read from peripheral 2, adr=4'b1001, peri 2 acks after 2 cycles with data 8'hA5:
  - peri_wb_stb_o=4'b0100 and peri_wb_adr_o=2'b01 throughout BUSY;
  - ctrl_wb_ack_o pulses once with ctrl_wb_dat_o=8'hA5; err_o=0.
- Write to peripheral 0, adr=0, dat=8'h3C, peri 0 acks in its first cycle -> peri_wb_we_o=1 and peri_wb_dat_o=8'h3C; ctrl ack 2 cycles after the stb edge.
- Unmapped access with PeriN=3, adr=4'b1100 -> no peri strobe; ack next cycle with dat=0 and err_o=1; err_cnt_o=1.
- Timeout with TimeoutCycles=15, peri 1 never acks:
  - stb held for 15 cycles, then dropped;
  - ack with dat=0 and err_o=1;
  - a peri 1 ack arriving 2 cycles later is ignored, with no second ack.
- Edge cases:
  - peri 3 acks together with a spurious peri 0 ack, sel=3 -> peri 3 data returned.
  - 300 unmapped accesses -> err_cnt_o saturates at 255.
  - stb held through RESP -> exactly one ack per 2-cycle unmapped transaction.
